// File: rtl/spram_lsu.sv
// spram_lsu: word-organised single-port data RAM on the RV32 load/store path.
// Optional macro SPRAM_LSU_CLEAR_EN zeroes every word after reset before accepting traffic.
module spram_lsu #(
  parameter int ADDR_WIDTH  = 18,
  parameter int DEPTH_WORDS = 65536
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int MA_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH_WORDS);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  // Byte-lane enables for a store of the given width at byte offset a.
  function automatic logic [3:0] lane_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   lane_en = 4'b0001 << a;
      2'b01:   lane_en = a[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its byte.
  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   lane_data = {4{wd[7:0]}};
      2'b01:   lane_data = {2{wd[15:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {a, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_ext = {24'd0, sh[7:0]};
      3'b101:  load_ext = {16'd0, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic            clr_we, clr_last;
  logic [MA_W-1:0] clr_addr;

`ifdef SPRAM_LSU_CLEAR_EN
  localparam logic [MA_W-1:0] LAST_IDX = MA_W'(DEPTH_WORDS - 1);
  logic [MA_W-1:0] clr_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                clr_cnt_q <= '0;
    else if (state_q == INIT) clr_cnt_q <= clr_cnt_q + 1'b1;
  end

  assign clr_addr  = clr_cnt_q;
  assign clr_last  = (clr_cnt_q == LAST_IDX);
  assign init_done = (state_q == RUN);
`else
  assign clr_addr  = '0;
  assign clr_last  = 1'b1;
  assign init_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    clr_we    = 1'b0;
    case (state_q)
      INIT: begin
`ifdef SPRAM_LSU_CLEAR_EN
        clr_we = 1'b1;
`endif
        if (clr_last) state_d = RUN;
      end
      RUN: req_ready = 1'b1;
    endcase
  end

  // p0: request decode and error screening at acceptance
  logic             acc_p0, err_p0, wr_p0, rd_p0, mis_p0, bad_f3_p0, oor_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             mem_we;
  logic [MA_W-1:0]  mem_addr;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wd;

  assign acc_p0    = req_valid && req_ready;
  assign idx_p0    = req_addr[ADDR_WIDTH-1:2];
  assign bad_f3_p0 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_we && req_funct3[2]);
  assign mis_p0    = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign oor_p0    = ({1'b0, idx_p0} >= DEPTH_L);
  assign err_p0    = bad_f3_p0 || mis_p0 || oor_p0;
  assign wr_p0     = acc_p0 && req_we && !err_p0;
  assign rd_p0     = acc_p0 && !req_we && !err_p0;

  assign mem_we   = clr_we || wr_p0;
  assign mem_addr = clr_we ? clr_addr : idx_p0[MA_W-1:0];
  assign mem_be   = clr_we ? 4'b1111 : lane_en(req_funct3, req_addr[1:0]);
  assign mem_wd   = clr_we ? 32'd0 : lane_data(req_funct3, req_wdata);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr][i] <= mem_wd[8*i +: 8];
    end
  end

  // p1: registered response, one cycle after acceptance
  logic        vld_p1, err_p1;
  logic [31:0] rdata_p1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= acc_p0;
      err_p1   <= acc_p0 && err_p0;
      rdata_p1 <= rd_p0 ? load_ext(req_funct3, req_addr[1:0], mem[mem_addr]) : 32'd0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_err   = err_p1;
  assign rsp_rdata = rdata_p1;

endmodule

// File: tb/tb_spram_lsu.sv
// Directed self-checking bench for spram_lsu (DEPTH_WORDS = 16); follows SPRAM_LSU_CLEAR_EN.
module tb_spram_lsu;
  localparam int AW = 18;

`ifdef SPRAM_LSU_CLEAR_EN
  localparam int EXP_RDY_CYC = 17;
  localparam logic EXP_DONE_RST = 1'b0;
`else
  localparam int EXP_RDY_CYC = 2;
  localparam logic EXP_DONE_RST = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_funct3;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_err, init_done;
  logic [31:0]   rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  spram_lsu #(.ADDR_WIDTH(AW), .DEPTH_WORDS(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response cycle.
  task automatic xfer(input logic we, input logic [AW-1:0] addr, input logic [2:0] f3,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rd = rsp_rdata;
    er = rsp_err;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
  endtask

  // Counts cycles from reset release (release cycle = 1) until req_ready.
  task automatic wait_ready(output int cyc);
    cyc = 1;
    while (!req_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc;

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_funct3 = 3'b010; req_wdata = '0;
    #2;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err",   {31'd0, rsp_err}, 32'd0);
    chk("rst_done",  {31'd0, init_done}, {31'd0, EXP_DONE_RST});
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wait_ready(cyc);
    chk("ready_cycle", cyc, EXP_RDY_CYC);
    chk("done_run", {31'd0, init_done}, 32'd1);

`ifdef SPRAM_LSU_CLEAR_EN
    xfer(1'b0, 18'h3C, 3'b010, 32'd0, rd, er);
    chk("clr_lw3c", rd, 32'h0000_0000);
    chk("clr_lw3c_err", {31'd0, er}, 32'd0);
`else
    xfer(1'b1, 18'h3C, 3'b010, 32'h0BAD_F00D, rd, er);
    xfer(1'b0, 18'h3C, 3'b010, 32'd0, rd, er);
    chk("top_word", rd, 32'h0BAD_F00D);
`endif

    // Byte/half lane stores
    xfer(1'b1, 18'h10, 3'b010, 32'h1122_3344, rd, er);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_err", {31'd0, er}, 32'd0);
    xfer(1'b1, 18'h11, 3'b000, 32'h0000_00AA, rd, er);
    xfer(1'b1, 18'h12, 3'b001, 32'h0000_BEEF, rd, er);
    xfer(1'b0, 18'h10, 3'b010, 32'd0, rd, er);
    chk("lanes_lw", rd, 32'hBEEF_AA44);

    // Load extension
    xfer(1'b0, 18'h11, 3'b000, 32'd0, rd, er); chk("lb",  rd, 32'hFFFF_FFAA);
    xfer(1'b0, 18'h11, 3'b100, 32'd0, rd, er); chk("lbu", rd, 32'h0000_00AA);
    xfer(1'b0, 18'h12, 3'b001, 32'd0, rd, er); chk("lh",  rd, 32'hFFFF_BEEF);
    xfer(1'b0, 18'h12, 3'b101, 32'd0, rd, er); chk("lhu", rd, 32'h0000_BEEF);
    xfer(1'b0, 18'h10, 3'b000, 32'd0, rd, er); chk("lb0", rd, 32'h0000_0044);

    // Rejected requests: error, zero data, memory untouched
    xfer(1'b1, 18'h12, 3'b010, 32'h5555_5555, rd, er);
    chk("err_sw_mis", {31'd0, er}, 32'd1); chk("err_sw_mis_d", rd, 32'd0);
    xfer(1'b0, 18'h13, 3'b001, 32'd0, rd, er);
    chk("err_lh_mis", {31'd0, er}, 32'd1); chk("err_lh_mis_d", rd, 32'd0);
    xfer(1'b0, 18'h10, 3'b011, 32'd0, rd, er);
    chk("err_f3_011", {31'd0, er}, 32'd1); chk("err_f3_011_d", rd, 32'd0);
    xfer(1'b1, 18'h10, 3'b100, 32'h0000_0077, rd, er);
    chk("err_sbu", {31'd0, er}, 32'd1);
    xfer(1'b1, 18'h40, 3'b010, 32'h6666_6666, rd, er);
    chk("err_oor_sw", {31'd0, er}, 32'd1);
    xfer(1'b0, 18'h40, 3'b010, 32'd0, rd, er);
    chk("err_oor_lw", {31'd0, er}, 32'd1); chk("err_oor_lw_d", rd, 32'd0);
    xfer(1'b0, 18'h10, 3'b010, 32'd0, rd, er);
    chk("after_err_lw", rd, 32'hBEEF_AA44);
    chk("after_err_ok", {31'd0, er}, 32'd0);
    xfer(1'b0, 18'h00, 3'b010, 32'd0, rd, er);
`ifdef SPRAM_LSU_CLEAR_EN
    chk("oor_no_alias", rd, 32'd0);
`endif

    // Back-to-back store then load of the same word
    req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h20;
    req_funct3 = 3'b010; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    chk("b2b_st_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_st_rdata", rsp_rdata, 32'd0);
    req_we = 1'b0; req_wdata = 32'd0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_ld_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_raw", rsp_rdata, 32'hDEAD_BEEF);
    @(posedge clk); @(negedge clk);
    chk("b2b_idle", {31'd0, rsp_valid}, 32'd0);

    // Reset asserted right after a load is accepted
    req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h10; req_funct3 = 3'b010;
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_done",  {31'd0, init_done}, {31'd0, EXP_DONE_RST});
    @(negedge clk);
    chk("mid_rst_ign", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b0;
    rstn = 1'b1;
    wait_ready(cyc);
    chk("rerun_cycle", cyc, EXP_RDY_CYC);
`ifdef SPRAM_LSU_CLEAR_EN
    xfer(1'b0, 18'h10, 3'b010, 32'd0, rd, er);
    chk("recleared", rd, 32'd0);
`else
    xfer(1'b1, 18'h24, 3'b001, 32'h0000_8001, rd, er);
    xfer(1'b0, 18'h24, 3'b001, 32'd0, rd, er);
    chk("post_rst_lh", rd, 32'hFFFF_8001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
